// File: rtl/tm1638_responder.sv
// TM1638 device-side responder: decodes host STB/CLK/DIO frames, holds display RAM and brightness, returns key bytes.
// Optional protocol error counter enabled by defining TM1638_RESP_ERRCNT_EN.
module tm1638_responder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk_5MHz,
    input  logic         n_rst,
    input  logic         tm1638_strobe,
    input  logic         tm1638_clk,
    input  logic         tm1638_dio_in,
    output logic         tm1638_dio_out,
    output logic         tm1638_dio_oe,
    input  logic [7:0]   keys,
    output logic [127:0] display_ram,
    output logic         display_on,
    output logic [2:0]   display_level,
    output logic         frame_done,
    output logic         read_done
`ifdef TM1638_RESP_ERRCNT_EN
    ,
    output logic [7:0]   err_count
`endif
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_WDATA  = 3'd2;
    localparam logic [2:0] ST_RDATA  = 3'd3;
    localparam logic [2:0] ST_IGNORE = 3'd4;

    localparam int unsigned RD_BITS = 32;
    localparam int unsigned RD_CW   = 6;

    logic [2:0] state;
    logic [2:0] state_next;

    logic [SYNC_STAGES-1:0] stb_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] dio_sync;
    logic                   stb_prev;
    logic                   sclk_prev;

    logic [2:0]       bit_cnt;
    logic [6:0]       shreg;
    logic [3:0]       addr;
    logic             mode_read;
    logic             autoinc;
    logic             wrote;
    logic [7:0]       key_snap;
    logic [RD_CW-1:0] rd_bits;

    logic        stb_s, sclk_s, dio_s;
    logic        stb_rise_c, stb_fall_c;
    logic        sclk_rise_c, sclk_fall_c;
    logic        rx_state_c;
    logic        byte_done_c;
    logic [7:0]  rx_byte_c;
    logic [31:0] key_word_c;

    // Input synchronisers plus one history flop for edge detection
    always_ff @(posedge clk_5MHz or negedge n_rst) begin
        if (!n_rst) begin
            stb_sync  <= '1;
            sclk_sync <= '1;
            dio_sync  <= '1;
            stb_prev  <= 1'b1;
            sclk_prev <= 1'b1;
        end else begin
            stb_sync  <= {stb_sync[SYNC_STAGES-2:0], tm1638_strobe};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], tm1638_clk};
            dio_sync  <= {dio_sync[SYNC_STAGES-2:0], tm1638_dio_in};
            stb_prev  <= stb_sync[SYNC_STAGES-1];
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    // STB rise takes priority: a coincident sclk edge is dropped
    always_comb begin
        stb_s       = stb_sync[SYNC_STAGES-1];
        sclk_s      = sclk_sync[SYNC_STAGES-1];
        dio_s       = dio_sync[SYNC_STAGES-1];
        stb_rise_c  = stb_s & ~stb_prev;
        stb_fall_c  = ~stb_s & stb_prev;
        sclk_rise_c = sclk_s & ~sclk_prev & ~stb_rise_c;
        sclk_fall_c = ~sclk_s & sclk_prev & ~stb_rise_c;
        rx_state_c  = (state == ST_CMD) || (state == ST_WDATA) || (state == ST_IGNORE);
        byte_done_c = rx_state_c && sclk_rise_c && (bit_cnt == 3'd7);
        rx_byte_c   = {dio_s, shreg};
    end

    // Key bytes: byte n carries keys[7-n] in bit0 and keys[3-n] in bit4
    always_comb begin
        key_word_c = '0;
        for (int n = 0; n < 4; n++) begin
            key_word_c[8*n]     = key_snap[7-n];
            key_word_c[8*n + 4] = key_snap[3-n];
        end
    end

    always_ff @(posedge clk_5MHz or negedge n_rst) begin
        if (!n_rst) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (stb_rise_c) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (stb_fall_c) state_next = ST_CMD;
                end
                ST_CMD: begin
                    if (byte_done_c) begin
                        case (rx_byte_c[7:6])
                            2'b01:   state_next = rx_byte_c[1] ? ST_RDATA : ST_IGNORE;
                            2'b11:   state_next = mode_read ? ST_IGNORE : ST_WDATA;
                            default: state_next = ST_IGNORE;
                        endcase
                    end
                end
                ST_WDATA, ST_RDATA, ST_IGNORE: state_next = state;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Shift/decode datapath, RAM, display control and read-back driver
    always_ff @(posedge clk_5MHz or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt        <= '0;
            shreg          <= '0;
            addr           <= '0;
            mode_read      <= 1'b0;
            autoinc        <= 1'b1;
            wrote          <= 1'b0;
            key_snap       <= '0;
            rd_bits        <= '0;
            display_ram    <= '0;
            display_on     <= 1'b0;
            display_level  <= '0;
            tm1638_dio_oe  <= 1'b0;
            tm1638_dio_out <= 1'b1;
            frame_done     <= 1'b0;
            read_done      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            read_done  <= 1'b0;
            if (stb_rise_c) begin
                bit_cnt        <= '0;
                rd_bits        <= '0;
                tm1638_dio_oe  <= 1'b0;
                tm1638_dio_out <= 1'b1;
                frame_done     <= wrote;
                wrote          <= 1'b0;
            end else begin
                if ((state == ST_IDLE) && stb_fall_c) begin
                    bit_cnt <= '0;
                    wrote   <= 1'b0;
                end
                if (rx_state_c && sclk_rise_c) begin
                    shreg   <= {dio_s, shreg[6:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if ((state == ST_CMD) && byte_done_c) begin
                    case (rx_byte_c[7:6])
                        2'b01: begin
                            mode_read <= rx_byte_c[1];
                            autoinc   <= ~rx_byte_c[2];
                            key_snap  <= keys;
                            rd_bits   <= '0;
                        end
                        2'b10: begin
                            display_on    <= rx_byte_c[3];
                            display_level <= rx_byte_c[2:0];
                        end
                        2'b11:   addr <= rx_byte_c[3:0];
                        default: ;
                    endcase
                end
                if ((state == ST_WDATA) && byte_done_c) begin
                    display_ram[{addr, 3'b000} +: 8] <= rx_byte_c;
                    wrote <= 1'b1;
                    if (autoinc) addr <= addr + 4'd1;
                end
                if (state == ST_RDATA) begin
                    if (sclk_fall_c) begin
                        if (rd_bits < RD_CW'(RD_BITS)) begin
                            tm1638_dio_oe  <= 1'b1;
                            tm1638_dio_out <= key_word_c[rd_bits[4:0]];
                        end else begin
                            tm1638_dio_oe  <= 1'b0;
                            tm1638_dio_out <= 1'b1;
                        end
                    end
                    // Host has sampled the driven bit on this rise
                    if (sclk_rise_c && tm1638_dio_oe && (rd_bits < RD_CW'(RD_BITS))) begin
                        rd_bits <= rd_bits + RD_CW'(1);
                        if (rd_bits == RD_CW'(RD_BITS - 1)) read_done <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef TM1638_RESP_ERRCNT_EN
    logic err_inc_c;

    // Partial byte at STB rise, invalid command, or data arriving while ignored
    always_comb begin
        err_inc_c = 1'b0;
        if (stb_rise_c && rx_state_c && (bit_cnt != 3'd0)) err_inc_c = 1'b1;
        if ((state == ST_CMD) && byte_done_c && (rx_byte_c[7:6] == 2'b00)) err_inc_c = 1'b1;
        if ((state == ST_IGNORE) && byte_done_c) err_inc_c = 1'b1;
    end

    always_ff @(posedge clk_5MHz or negedge n_rst) begin
        if (!n_rst)                             err_count <= '0;
        else if (err_inc_c && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
`endif

endmodule
